// File: rtl/cv32e40p_apu_multi_disp.sv
// APU dispatcher: fans one core APU port out to NUM_UNITS execution units,
// tracks every outstanding operation in an issue-order FIFO and hands the
// results back to the core strictly in issue order through per-unit FIFOs.
module cv32e40p_apu_multi_disp #(
    parameter int unsigned NUM_UNITS       = 2,
    parameter int unsigned NARGS           = 3,
    parameter int unsigned WOP             = 6,
    parameter int unsigned NDSFLAGS        = 15,
    parameter int unsigned NUSFLAGS        = 5,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned RESP_DEPTH      = 2,
    localparam int unsigned SW             = $clog2(NUM_UNITS + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            apu_req_i,
    output logic                            apu_gnt_o,
    input  logic [SW-1:0]                   apu_sel_i,
    input  logic [NARGS*32-1:0]             apu_operands_i,
    input  logic [WOP-1:0]                  apu_op_i,
    input  logic [NDSFLAGS-1:0]             apu_flags_i,
    output logic                            apu_rvalid_o,
    output logic [31:0]                     apu_result_o,
    output logic [NUSFLAGS-1:0]             apu_rflags_o,
    output logic [NUM_UNITS-1:0]            unit_req_o,
    input  logic [NUM_UNITS-1:0]            unit_gnt_i,
    output logic [NARGS*32-1:0]             unit_operands_o,
    output logic [WOP-1:0]                  unit_op_o,
    output logic [NDSFLAGS-1:0]             unit_flags_o,
    input  logic [NUM_UNITS-1:0]            unit_rvalid_i,
    input  logic [NUM_UNITS*32-1:0]         unit_result_i,
    input  logic [NUM_UNITS*NUSFLAGS-1:0]   unit_rflags_i,
    output logic                            overflow_o
);

    localparam int unsigned OAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OCW = OAW + 1;
    localparam int unsigned RAW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned RW  = 32 + NUSFLAGS;

    typedef logic [RW-1:0] rentry_t;

    // Result FIFO pointer advance with wrap for non-power-of-2 depths.
    function automatic logic [RAW-1:0] rptr_inc(input logic [RAW-1:0] p);
        if (p == RAW'(RESP_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + RAW'(1);
        end
    endfunction

    // Issue-order FIFO: which unit each in-flight op went to, valid=0 for bad selects
    logic [SW-1:0]              ord_sel_q [MAX_OUTSTANDING];
    logic [SW-1:0]              ord_sel_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] ord_vld_q, ord_vld_d;
    logic [OAW-1:0]             ord_wptr_q, ord_wptr_d, ord_rptr_q, ord_rptr_d;
    logic [OCW-1:0]             ord_cnt_q, ord_cnt_d;

    // Per-unit result FIFOs and outstanding-op counters
    rentry_t        res_mem_q  [NUM_UNITS][RESP_DEPTH];
    rentry_t        res_mem_d  [NUM_UNITS][RESP_DEPTH];
    logic [RAW-1:0] res_wptr_q [NUM_UNITS];
    logic [RAW-1:0] res_wptr_d [NUM_UNITS];
    logic [RAW-1:0] res_rptr_q [NUM_UNITS];
    logic [RAW-1:0] res_rptr_d [NUM_UNITS];
    logic [CW-1:0]  res_occ_q  [NUM_UNITS];
    logic [CW-1:0]  res_occ_d  [NUM_UNITS];
    logic [CW-1:0]  cnt_q      [NUM_UNITS];
    logic [CW-1:0]  cnt_d      [NUM_UNITS];

    logic                 rvalid_q, rvalid_d;
    logic [31:0]          result_q, result_d;
    logic [NUSFLAGS-1:0]  rflags_q, rflags_d;
    logic                 overflow_q, overflow_d;

    logic                 sel_ok_s, ord_full_s, gnt_s;
    logic [NUM_UNITS-1:0] unit_req_s, unit_issue_s;
    logic [NUM_UNITS-1:0] spur_s, res_push_s, res_pop_s;
    rentry_t              res_in_s [NUM_UNITS];
    logic [SW-1:0]        head_sel_s;
    logic                 head_vld_s, ret_s;
    rentry_t              ret_data_s;

    assign unit_operands_o = apu_operands_i;
    assign unit_op_o       = apu_op_i;
    assign unit_flags_o    = apu_flags_i;
    assign unit_req_o      = unit_req_s;
    assign apu_gnt_o       = gnt_s;
    assign apu_rvalid_o    = rvalid_q;
    assign apu_result_o    = result_q;
    assign apu_rflags_o    = rflags_q;
    assign overflow_o      = overflow_q;

    // Issue: route the request to the selected unit unless tracking space is exhausted
    always_comb begin
        sel_ok_s   = (apu_sel_i < SW'(NUM_UNITS));
        ord_full_s = (ord_cnt_q == OCW'(MAX_OUTSTANDING));
        unit_req_s = '0;
        gnt_s      = 1'b0;
        if (sel_ok_s) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (apu_sel_i == SW'(u)) begin
                    unit_req_s[u] = apu_req_i & ~ord_full_s & (cnt_q[u] < CW'(RESP_DEPTH));
                    gnt_s         = unit_req_s[u] & unit_gnt_i[u];
                end else begin
                    unit_req_s[u] = 1'b0;
                end
            end
        end else begin
            gnt_s = apu_req_i & ~ord_full_s;
        end
        unit_issue_s = unit_req_s & unit_gnt_i;
    end

    // Completion filtering and in-order return selection (incoming result may bypass an empty FIFO)
    always_comb begin
        head_sel_s = ord_sel_q[ord_rptr_q];
        head_vld_s = ord_vld_q[ord_rptr_q];
        ret_s      = 1'b0;
        ret_data_s = '0;
        res_pop_s  = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            spur_s[u]     = unit_rvalid_i[u] & (res_occ_q[u] == cnt_q[u]);
            res_push_s[u] = unit_rvalid_i[u] & ~spur_s[u];
            res_in_s[u]   = {unit_rflags_i[u*NUSFLAGS +: NUSFLAGS], unit_result_i[u*32 +: 32]};
        end
        if (ord_cnt_q != '0) begin
            if (head_vld_s) begin
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (head_sel_s == SW'(u) && res_occ_q[u] != '0) begin
                        ret_s        = 1'b1;
                        ret_data_s   = res_mem_q[u][res_rptr_q[u]];
                        res_pop_s[u] = 1'b1;
                    end else if (head_sel_s == SW'(u) && res_push_s[u]) begin
                        ret_s        = 1'b1;
                        ret_data_s   = res_in_s[u];
                        res_pop_s[u] = 1'b1;
                    end else begin
                        res_pop_s[u] = 1'b0;
                    end
                end
            end else begin
                ret_s      = 1'b1;
                ret_data_s = {{NUSFLAGS{1'b1}}, 32'h0000_0000};
            end
        end else begin
            ret_s = 1'b0;
        end
    end

    // Next-state for order FIFO, result FIFOs, counters and registered outputs
    always_comb begin
        ord_sel_d  = ord_sel_q;
        ord_vld_d  = ord_vld_q;
        ord_wptr_d = ord_wptr_q;
        ord_rptr_d = ord_rptr_q;
        res_mem_d  = res_mem_q;
        res_wptr_d = res_wptr_q;
        res_rptr_d = res_rptr_q;
        res_occ_d  = res_occ_q;
        cnt_d      = cnt_q;
        if (gnt_s) begin
            ord_sel_d[ord_wptr_q] = apu_sel_i;
            ord_vld_d[ord_wptr_q] = sel_ok_s;
            ord_wptr_d            = ord_wptr_q + OAW'(1);
        end else begin
            ord_wptr_d = ord_wptr_q;
        end
        if (ret_s) begin
            ord_rptr_d = ord_rptr_q + OAW'(1);
        end else begin
            ord_rptr_d = ord_rptr_q;
        end
        ord_cnt_d = ord_cnt_q + OCW'(gnt_s) - OCW'(ret_s);
        for (int u = 0; u < NUM_UNITS; u++) begin
            cnt_d[u]     = cnt_q[u] + CW'(unit_issue_s[u]) - CW'(res_pop_s[u]);
            res_occ_d[u] = res_occ_q[u] + CW'(res_push_s[u]) - CW'(res_pop_s[u]);
            if (res_push_s[u] && !(res_pop_s[u] && res_occ_q[u] == '0)) begin
                res_mem_d[u][res_wptr_q[u]] = res_in_s[u];
                res_wptr_d[u]               = rptr_inc(res_wptr_q[u]);
            end else begin
                res_wptr_d[u] = res_wptr_q[u];
            end
            if (res_pop_s[u] && res_occ_q[u] != '0) begin
                res_rptr_d[u] = rptr_inc(res_rptr_q[u]);
            end else begin
                res_rptr_d[u] = res_rptr_q[u];
            end
        end
        rvalid_d   = ret_s;
        overflow_d = overflow_q | (|spur_s);
        if (ret_s) begin
            result_d = ret_data_s[31:0];
            rflags_d = ret_data_s[RW-1:32];
        end else begin
            result_d = result_q;
            rflags_d = rflags_q;
        end
    end

    // State registers; reset discards all in-flight operations
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ord_sel_q[i] <= '0;
            end
            ord_vld_q  <= '0;
            ord_wptr_q <= '0;
            ord_rptr_q <= '0;
            ord_cnt_q  <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                for (int d = 0; d < RESP_DEPTH; d++) begin
                    res_mem_q[u][d] <= '0;
                end
                res_wptr_q[u] <= '0;
                res_rptr_q[u] <= '0;
                res_occ_q[u]  <= '0;
                cnt_q[u]      <= '0;
            end
            rvalid_q   <= 1'b0;
            result_q   <= 32'h0000_0000;
            rflags_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            ord_sel_q  <= ord_sel_d;
            ord_vld_q  <= ord_vld_d;
            ord_wptr_q <= ord_wptr_d;
            ord_rptr_q <= ord_rptr_d;
            ord_cnt_q  <= ord_cnt_d;
            res_mem_q  <= res_mem_d;
            res_wptr_q <= res_wptr_d;
            res_rptr_q <= res_rptr_d;
            res_occ_q  <= res_occ_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            result_q   <= result_d;
            rflags_q   <= rflags_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/cv32e40p_apu_multi_disp.md
Name: cv32e40p_apu_multi_disp

Overview:
- Parametrised APU dispatcher between the core's single APU port and NUM_UNITS APU units (FPU, DSP accelerators, ...).
- Routes each accepted request to the unit chosen by a select field and tracks all outstanding operations.
- Results are returned to the core strictly in issue order, even when units complete out of order.
- Replaces the single-FPU hookup in the top level, generalising it to N units with multi-outstanding support.

Parameters:
NUM_UNITS, 2, number of attached APU units (1..8)
NARGS, 3, operands per request
WOP, 6, opcode width
NDSFLAGS, 15, downstream flag width
NUSFLAGS, 5, upstream (result) flag width
MAX_OUTSTANDING, 4, depth of issue-order FIFO (power of 2, >=2)
RESP_DEPTH, 2, per-unit result FIFO depth (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
apu_req_i  in  1  core request
apu_gnt_o  out  1  request accepted this cycle
apu_sel_i  in  SW=$clog2(NUM_UNITS+1)  target unit index
apu_operands_i  in  NARGS*32  operands, arg k at [32k+:32]
apu_op_i  in  WOP  opcode
apu_flags_i  in  NDSFLAGS  downstream flags
apu_rvalid_o  out  1  result valid (1-cycle pulse)
apu_result_o  out  32  result
apu_rflags_o  out  NUSFLAGS  result flags
unit_req_o  out  NUM_UNITS  per-unit request
unit_gnt_i  in  NUM_UNITS  per-unit grant
unit_operands_o  out  NARGS*32  operands, broadcast to all units
unit_op_o  out  WOP  opcode, broadcast
unit_flags_o  out  NDSFLAGS  flags, broadcast
unit_rvalid_i  in  NUM_UNITS  per-unit result pulse
unit_result_i  in  NUM_UNITS*32  unit u result at [32u+:32]
unit_rflags_i  in  NUM_UNITS*NUSFLAGS  unit u flags
overflow_o  out  1  sticky spurious-result error

Behaviour:
- Reset: all FIFOs empty, all counters 0. apu_rvalid_o, apu_result_o, apu_rflags_o, overflow_o = 0.
- Broadcast outputs: unit_operands_o, unit_op_o and unit_flags_o pass straight through from the core inputs (combinational).
- Issue, valid select (sel < NUM_UNITS):
  - unit_req_o[sel] = apu_req_i & !ord_full & (cnt[sel] < RESP_DEPTH). All other unit_req_o bits are 0.
  - apu_gnt_o = unit_req_o[sel] & unit_gnt_i[sel] (combinational).
  - On grant: push {sel, valid=1} into the order FIFO and increment cnt[sel].
- Issue, invalid select (sel >= NUM_UNITS):
  - apu_gnt_o = apu_req_i & !ord_full. No unit_req_o is raised.
  - Push {sel, valid=0}.
- Stall: while not granted, the core holds its request stable. The dispatcher keeps its unit_req_o stable as long as cnt and ord_full do not change.
- Completion:
  - unit_rvalid_i[u] pushes {result, rflags} into result FIFO u.
  - If result FIFO u occupancy already equals cnt[u], the pulse is spurious: drop it and set overflow_o (sticky until reset).
  - Result FIFO u never exceeds RESP_DEPTH.
- Return, at most one per cycle, registered:
  - Head valid=1 and result FIFO[head.sel] non-empty: next cycle apu_rvalid_o=1 with that entry. Pop the result FIFO and the order FIFO, decrement cnt[head.sel].
  - Head valid=0: next cycle apu_rvalid_o=1, result=32'h0, rflags all ones. Pop the order FIFO.
  - Otherwise apu_rvalid_o=0. Result/flags hold their previous value when rvalid=0.
- Latency: a unit_rvalid_i at cycle t whose entry is already at the head gives apu_rvalid_o at t+1.
- Simultaneous events:
  - Grant and return on the same unit in one cycle: cnt unchanged.
  - Push and pop on the same FIFO in one cycle is legal when full or empty.
  - A result arriving into an empty FIFO at the head is returned the next cycle (FIFO pass-through via register).
- Full: when ord_full, no grant of either kind, even if a pop happens the same cycle (no same-cycle refill).
- Reset mid-operation: all in-flight state is discarded. Units are reset by the same rst_ni.

Test Plan:
- Single op: sel=0, unit0 gnt at once, rvalid 3 cycles later with result 32'hDEADBEEF, flags 5'h01 -> apu_rvalid_o one cycle later with DEADBEEF/01; cnt[0] back to 0.
- Out-of-order: issue A->unit0, B->unit1; unit1 completes (32'h2) before unit0 (32'h1) -> core sees 32'h1 then 32'h2 on consecutive cycles.
- Backpressure: RESP_DEPTH=2, three ops to unit0 with no completions -> third request has unit_req_o[0]=0 and gnt=0 until the first result returns.
- Order full: MAX_OUTSTANDING=4, four grants without completions -> fifth req gets no gnt; gnt resumes the cycle after the first pop.
- Invalid select: sel=3 with NUM_UNITS=2 -> immediate gnt, no unit_req_o; in-order return of result 0, rflags 5'h1F.
- Spurious result and reset: unit1 rvalid with cnt[1]=0 -> overflow_o=1, no core response; assert rst_ni=0 mid-burst -> all outputs 0, a fresh op then completes normally.
